// File: rtl/exc_pkg.sv
// Shared definitions for the write-back exception commit unit.
// ws_exc bit positions are in priority order (lowest index wins).
// The interrupt request is separate and always outranks them.
package exc_pkg;

  localparam int EXC_W = 7;

  // ws_exc bit indices, highest priority first
  localparam int EXC_ADEL_IF = 0;
  localparam int EXC_RI      = 1;
  localparam int EXC_OV      = 2;
  localparam int EXC_SYS     = 3;
  localparam int EXC_BP      = 4;
  localparam int EXC_ADEL_LD = 5;
  localparam int EXC_ADES    = 6;

  localparam logic [4:0] EXCODE_INT  = 5'd0;
  localparam logic [4:0] EXCODE_ADEL = 5'd4;
  localparam logic [4:0] EXCODE_ADES = 5'd5;
  localparam logic [4:0] EXCODE_SYS  = 5'd8;
  localparam logic [4:0] EXCODE_BP   = 5'd9;
  localparam logic [4:0] EXCODE_RI   = 5'd10;
  localparam logic [4:0] EXCODE_OV   = 5'd12;

  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC00380;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  // ExcCode reported for a given ws_exc bit index
  function automatic logic [4:0] exc_bit_code(input int idx);
    case (idx)
      EXC_ADEL_IF: exc_bit_code = EXCODE_ADEL;
      EXC_RI:      exc_bit_code = EXCODE_RI;
      EXC_OV:      exc_bit_code = EXCODE_OV;
      EXC_SYS:     exc_bit_code = EXCODE_SYS;
      EXC_BP:      exc_bit_code = EXCODE_BP;
      EXC_ADEL_LD: exc_bit_code = EXCODE_ADEL;
      EXC_ADES:    exc_bit_code = EXCODE_ADES;
      default:     exc_bit_code = EXCODE_INT;
    endcase
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Priority encoder: {int_req, exc bitmap} -> {any, excode}.
// Ports: int_req, exc[EXC_W] in; any, excode[5] out.
// Purely combinational, zero latency, no backpressure.
module exc_prio_enc
  import exc_pkg::*;
(
  input  logic             int_req,
  input  logic [EXC_W-1:0] exc,
  output logic             any,
  output logic [4:0]       excode
);

  always_comb begin
    any    = int_req | (|exc);
    excode = EXCODE_INT;
    if (!int_req) begin
      // Walk from lowest priority up so the lowest set index is written last.
      for (int i = EXC_W - 1; i >= 0; i--) begin
        if (exc[i]) excode = exc_bit_code(i);
      end
    end
  end

endmodule

// File: rtl/wb_exc_commit.sv
// Exception/ERET/MTC0 commit at write-back; drives the CP0 port, flushes, then redirects fetch.
// Ports: ws_* retiring instruction, cp0_* status in / control out, flush, redirect valid/ready, exc_count.
// CP0 controls are combinational in the commit cycle; redirect held until redirect_ready.
module wb_exc_commit
  import exc_pkg::*;
#(
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEFAULT,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ws_valid,
  output logic             ws_ready,
  input  logic [31:0]      ws_pc,
  input  logic             ws_bd,
  input  logic [6:0]       ws_exc,
  input  logic             ws_eret,
  input  logic             ws_mtc0,
  input  logic [4:0]       ws_cp0_addr,
  input  logic [31:0]      ws_rt_value,
  input  logic             cp0_status_exl,
  input  logic             cp0_status_ie,
  input  logic [7:0]       cp0_status_im,
  input  logic [7:0]       cp0_cause_ip,
  input  logic [31:0]      cp0_epc,
  output logic             cp0_ex,
  output logic             cp0_bd,
  output logic [4:0]       cp0_excode,
  output logic             cp0_eret,
  output logic             cp0_we,
  output logic [4:0]       cp0_waddr,
  output logic [31:0]      cp0_wdata,
  output logic             flush,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  input  logic             redirect_ready,
  output logic [CNT_W-1:0] exc_count
);

  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  state_e             state_q, state_d;
  logic [FC_W-1:0]    flush_cnt_q, flush_cnt_d;
  logic [31:0]        redirect_pc_q, redirect_pc_d;
  logic [CNT_W-1:0]   exc_count_q, exc_count_d;

  logic       int_req;
  logic       exc_any;
  logic [4:0] exc_code;
  logic       idle_vld;

  assign int_req = cp0_status_ie & ~cp0_status_exl & (|(cp0_cause_ip & cp0_status_im));

  exc_prio_enc u_prio (
    .int_req (int_req),
    .exc     (ws_exc),
    .any     (exc_any),
    .excode  (exc_code)
  );

  // Interrupts are only considered when a valid instruction sits in IDLE.
  assign idle_vld = (state_q == ST_IDLE) & ws_valid;

  always_comb begin
    state_d        = state_q;
    flush_cnt_d    = flush_cnt_q;
    redirect_pc_d  = redirect_pc_q;
    exc_count_d    = exc_count_q;
    ws_ready       = 1'b0;
    cp0_ex         = 1'b0;
    cp0_bd         = 1'b0;
    cp0_excode     = 5'd0;
    cp0_eret       = 1'b0;
    cp0_we         = 1'b0;
    cp0_waddr      = 5'd0;
    cp0_wdata      = 32'd0;
    flush          = 1'b0;
    redirect_valid = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ws_ready = 1'b1;
        if (idle_vld) begin
          if (exc_any) begin
            // Raw PC goes to EPC; CP0 applies the delay-slot adjustment.
            cp0_ex        = 1'b1;
            cp0_bd        = ws_bd;
            cp0_excode    = exc_code;
            cp0_wdata     = ws_pc;
            flush         = 1'b1;
            redirect_pc_d = EXC_VECTOR;
            flush_cnt_d   = FC_W'(FLUSH_CYCLES - 1);
            state_d       = ST_FLUSH;
            if (exc_count_q != {CNT_W{1'b1}}) exc_count_d = exc_count_q + 1'b1;
          end else if (ws_eret) begin
            cp0_eret      = 1'b1;
            flush         = 1'b1;
            redirect_pc_d = cp0_epc;
            flush_cnt_d   = FC_W'(FLUSH_CYCLES - 1);
            state_d       = ST_FLUSH;
          end else if (ws_mtc0) begin
            cp0_we    = 1'b1;
            cp0_waddr = ws_cp0_addr;
            cp0_wdata = ws_rt_value;
          end
        end
      end
      ST_FLUSH: begin
        flush = 1'b1;
        if (flush_cnt_q == '0) state_d = ST_REDIRECT;
        else                   flush_cnt_d = flush_cnt_q - 1'b1;
      end
      ST_REDIRECT: begin
        redirect_valid = 1'b1;
        if (redirect_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      flush_cnt_q   <= '0;
      redirect_pc_q <= 32'd0;
      exc_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      flush_cnt_q   <= flush_cnt_d;
      redirect_pc_q <= redirect_pc_d;
      exc_count_q   <= exc_count_d;
    end
  end

  assign redirect_pc = redirect_pc_q;
  assign exc_count   = exc_count_q;

endmodule

// File: tb/tb_wb_exc_commit.sv
module tb_wb_exc_commit;
  import exc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_valid, ws_ready, ws_bd, ws_eret, ws_mtc0;
  logic [31:0] ws_pc, ws_rt_value, cp0_epc;
  logic [6:0]  ws_exc;
  logic [4:0]  ws_cp0_addr;
  logic        cp0_status_exl, cp0_status_ie;
  logic [7:0]  cp0_status_im, cp0_cause_ip;
  logic        cp0_ex, cp0_bd, cp0_eret, cp0_we;
  logic [4:0]  cp0_excode, cp0_waddr;
  logic [31:0] cp0_wdata;
  logic        flush, redirect_valid, redirect_ready;
  logic [31:0] redirect_pc;
  logic [31:0] exc_count;

  always #5 clk = ~clk;

  wb_exc_commit #(.FLUSH_CYCLES(2), .EXC_VECTOR(32'hBFC00380), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .ws_valid(ws_valid), .ws_ready(ws_ready), .ws_pc(ws_pc), .ws_bd(ws_bd),
    .ws_exc(ws_exc), .ws_eret(ws_eret), .ws_mtc0(ws_mtc0),
    .ws_cp0_addr(ws_cp0_addr), .ws_rt_value(ws_rt_value),
    .cp0_status_exl(cp0_status_exl), .cp0_status_ie(cp0_status_ie),
    .cp0_status_im(cp0_status_im), .cp0_cause_ip(cp0_cause_ip), .cp0_epc(cp0_epc),
    .cp0_ex(cp0_ex), .cp0_bd(cp0_bd), .cp0_excode(cp0_excode), .cp0_eret(cp0_eret),
    .cp0_we(cp0_we), .cp0_waddr(cp0_waddr), .cp0_wdata(cp0_wdata),
    .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .exc_count(exc_count)
  );

  typedef struct {
    string       name;
    logic        valid;
    logic [31:0] pc;
    logic        bd;
    logic [6:0]  exc;
    logic        eret;
    logic        mtc0;
    logic [4:0]  addr;
    logic [31:0] rt;
    logic        ie;
    logic        exl;
    logic [7:0]  im;
    logic [7:0]  ip;
    logic [31:0] epc;
    logic        e_ex;
    logic        e_bd;
    logic [4:0]  e_code;
    logic        e_eret;
    logic        e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    logic        e_flush;
    logic [31:0] e_target;
  } vec_t;

  int total = 0;
  int bad   = 0;
  int model_count = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ws_valid = 0; ws_pc = 0; ws_bd = 0; ws_exc = 0; ws_eret = 0; ws_mtc0 = 0;
    ws_cp0_addr = 0; ws_rt_value = 0; cp0_status_exl = 0; cp0_status_ie = 0;
    cp0_status_im = 0; cp0_cause_ip = 0; cp0_epc = 0; redirect_ready = 0;
  endtask

  function automatic logic [6:0] b(input int idx);
    logic [6:0] one;
    one = 7'd1;
    return one << idx;
  endfunction

  vec_t vecs[$];

  initial begin
    // name valid pc bd exc eret mtc0 addr rt ie exl im ip epc | ex bd code eret we waddr wdata flush target
    vecs.push_back('{"no_valid_int_wait", 0, 32'hBFC00100, 0, b(EXC_OV), 0, 0, 0, 0, 1, 0, 8'hFF, 8'h80, 0,
                     0, 0, 0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{"ov", 1, 32'hBFC00100, 0, b(EXC_OV), 0, 0, 0, 0, 0, 0, 0, 0, 0,
                     1, 0, 12, 0, 0, 0, 32'hBFC00100, 1, 32'hBFC00380});
    vecs.push_back('{"ri_sys_bd", 1, 32'hBFC00204, 1, b(EXC_RI) | b(EXC_SYS), 0, 0, 0, 0, 0, 0, 0, 0, 0,
                     1, 1, 10, 0, 0, 0, 32'hBFC00204, 1, 32'hBFC00380});
    vecs.push_back('{"eret", 1, 32'hBFC00300, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 32'hBFC00040,
                     0, 0, 0, 1, 0, 0, 0, 1, 32'hBFC00040});
    vecs.push_back('{"int_over_ades", 1, 32'hBFC00010, 0, b(EXC_ADES), 0, 0, 0, 0, 1, 0, 8'hFF, 8'h80, 0,
                     1, 0, 0, 0, 0, 0, 32'hBFC00010, 1, 32'hBFC00380});
    vecs.push_back('{"ades_exl_masks", 1, 32'hBFC00010, 0, b(EXC_ADES), 0, 0, 0, 0, 1, 1, 8'hFF, 8'h80, 0,
                     1, 0, 5, 0, 0, 0, 32'hBFC00010, 1, 32'hBFC00380});
    vecs.push_back('{"mtc0", 1, 32'hBFC00020, 0, 0, 0, 1, 14, 32'h1234, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 1, 14, 32'h1234, 0, 0});
    vecs.push_back('{"mtc0_adel", 1, 32'hBFC00020, 0, b(EXC_ADEL_IF), 0, 1, 14, 32'h1234, 0, 0, 0, 0, 0,
                     1, 0, 4, 0, 0, 0, 32'hBFC00020, 1, 32'hBFC00380});
    vecs.push_back('{"eret_bp", 1, 32'hBFC00030, 0, b(EXC_BP), 1, 0, 0, 0, 0, 0, 0, 0, 32'hBFC00040,
                     1, 0, 9, 0, 0, 0, 32'hBFC00030, 1, 32'hBFC00380});
    vecs.push_back('{"sys_bp", 1, 32'hBFC00034, 0, b(EXC_SYS) | b(EXC_BP), 0, 0, 0, 0, 0, 0, 0, 0, 0,
                     1, 0, 8, 0, 0, 0, 32'hBFC00034, 1, 32'hBFC00380});
    vecs.push_back('{"adel_ld_ades", 1, 32'hBFC00038, 0, b(EXC_ADEL_LD) | b(EXC_ADES), 0, 0, 0, 0, 1, 0, 8'h0F, 8'h80, 0,
                     1, 0, 4, 0, 0, 0, 32'hBFC00038, 1, 32'hBFC00380});

    idle_inputs();
    reset = 1;
    tick(); tick();
    reset = 0;
    #1;
    chk("rst_ws_ready", 32'(ws_ready), 1);
    chk("rst_flush", 32'(flush), 0);
    chk("rst_redirect_valid", 32'(redirect_valid), 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_exc_count", exc_count, 0);
    chk("rst_cp0_ex", 32'(cp0_ex), 0);

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      ws_valid = v.valid; ws_pc = v.pc; ws_bd = v.bd; ws_exc = v.exc; ws_eret = v.eret;
      ws_mtc0 = v.mtc0; ws_cp0_addr = v.addr; ws_rt_value = v.rt;
      cp0_status_ie = v.ie; cp0_status_exl = v.exl; cp0_status_im = v.im;
      cp0_cause_ip = v.ip; cp0_epc = v.epc;
      #1;
      chk({v.name, ".ex"}, 32'(cp0_ex), 32'(v.e_ex));
      chk({v.name, ".bd"}, 32'(cp0_bd), 32'(v.e_bd));
      chk({v.name, ".excode"}, 32'(cp0_excode), 32'(v.e_code));
      chk({v.name, ".eret"}, 32'(cp0_eret), 32'(v.e_eret));
      chk({v.name, ".we"}, 32'(cp0_we), 32'(v.e_we));
      chk({v.name, ".waddr"}, 32'(cp0_waddr), 32'(v.e_waddr));
      chk({v.name, ".wdata"}, cp0_wdata, v.e_wdata);
      chk({v.name, ".flush"}, 32'(flush), 32'(v.e_flush));
      if (v.e_ex) model_count++;
      tick();
      if (v.e_flush) begin
        for (int k = 0; k < 2; k++) begin
          chk({v.name, ".flush_hold"}, 32'(flush), 1);
          chk({v.name, ".ready_low"}, 32'(ws_ready), 0);
          chk({v.name, ".no_ctl_in_flush"}, 32'({cp0_ex, cp0_eret, cp0_we}), 0);
          chk({v.name, ".rv_low"}, 32'(redirect_valid), 0);
          tick();
        end
        ws_valid = 0;
        #1;
        chk({v.name, ".flush_done"}, 32'(flush), 0);
        chk({v.name, ".rv"}, 32'(redirect_valid), 1);
        chk({v.name, ".rpc"}, redirect_pc, v.e_target);
        redirect_ready = 1;
        tick();
        redirect_ready = 0;
        #1;
        chk({v.name, ".rv_drop"}, 32'(redirect_valid), 0);
        chk({v.name, ".back_idle"}, 32'(ws_ready), 1);
      end else begin
        ws_valid = 0;
        #1;
        chk({v.name, ".we_one_cycle"}, 32'(cp0_we), 0);
        chk({v.name, ".no_flush"}, 32'(flush), 0);
      end
      chk({v.name, ".count"}, exc_count, 32'(model_count));
      idle_inputs();
    end

    // Redirect held off, then reset lands while waiting.
    ws_valid = 1; ws_pc = 32'hBFC00100; ws_exc = b(EXC_OV);
    #1;
    chk("hold.commit", 32'(cp0_ex), 1);
    model_count++;
    tick();
    ws_valid = 0; ws_exc = 0;
    tick(); tick();
    for (int k = 0; k < 2; k++) begin
      chk("hold.rv", 32'(redirect_valid), 1);
      chk("hold.rpc", redirect_pc, 32'hBFC00380);
      chk("hold.ready_low", 32'(ws_ready), 0);
      tick();
    end
    chk("hold.count", exc_count, 32'(model_count));
    reset = 1;
    tick();
    reset = 0;
    model_count = 0;
    #1;
    chk("hold_rst.rv", 32'(redirect_valid), 0);
    chk("hold_rst.ready", 32'(ws_ready), 1);
    chk("hold_rst.count", exc_count, 0);
    chk("hold_rst.rpc", redirect_pc, 0);

    // Reset during flush.
    ws_valid = 1; ws_eret = 1; cp0_epc = 32'hBFC00040;
    #1;
    chk("fl_rst.eret", 32'(cp0_eret), 1);
    tick();
    idle_inputs();
    reset = 1;
    #1;
    chk("fl_rst.flush_before", 32'(flush), 1);
    tick();
    reset = 0;
    #1;
    chk("fl_rst.flush", 32'(flush), 0);
    chk("fl_rst.ready", 32'(ws_ready), 1);
    tick(); tick(); tick();
    chk("fl_rst.no_redirect", 32'(redirect_valid), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
